// File: rtl/router_pkg.sv
// Router-wide constants, direction encoding and small helpers shared by router blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package router_pkg;

    localparam int NUM_PORTS        = 5;
    localparam int NUM_VCS          = 2;
    localparam int VC_ID_BITS       = $clog2(NUM_VCS);
    localparam int CREDIT_CTR_WIDTH = 4;
    localparam int PORT_BITS        = $clog2(NUM_PORTS);
    // Pointer width that stays legal even for a single-VC build.
    localparam int VC_PTR_BITS      = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1;

    localparam logic [CREDIT_CTR_WIDTH-1:0] CRED_ONE = CREDIT_CTR_WIDTH'(1);

    // Output direction requested by an input VC; DI means "no request".
    typedef enum logic [2:0] {
        LOCAL = 3'd0,
        EAST  = 3'd1,
        SOUTH = 3'd2,
        WEST  = 3'd3,
        NORTH = 3'd4,
        DI    = 3'd7
    } dir_t;

    // True when the direction names a real output port of this router.
    function automatic logic dir_valid(input dir_t d);
        return (d != DI) && (int'(d) < NUM_PORTS);
    endfunction

    // Output port index addressed by a direction.
    function automatic logic [PORT_BITS-1:0] dir_port(input dir_t d);
        return PORT_BITS'(d);
    endfunction

endpackage

// File: rtl/switch_allocator_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr_i, wrapping around.
// Latency: purely combinational.
// Backpressure: none; the caller owns the pointer and decides when to advance it.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic          any_o
);

    // Two passes: first the upper segment [ptr..N-1], then the wrapped segment [0..ptr-1].
    always_comb begin
        gnt_o = '0;
        any_o = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (!any_o && req_i[j] && (j >= int'(ptr_i))) begin
                gnt_o[j] = 1'b1;
                any_o    = 1'b1;
            end
        end
        for (int j = 0; j < N; j++) begin
            if (!any_o && req_i[j] && (j < int'(ptr_i))) begin
                gnt_o[j] = 1'b1;
                any_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/switch_allocator.sv
// Separable input-first round-robin switch allocator; SA_ISLIP_EN selects iSLIP input-pointer update.
// Latency: requests/credits sampled in cycle t, registered grant and crossbar selects visible in t+1.
// Backpressure: a request is only eligible while its downstream VC has a credit not already spent by last cycle's grant.
module switch_allocator
    import router_pkg::*;
(
    input  logic                        clk,
    input  logic                        arst_n,
    input  dir_t                        req_dir             [NUM_PORTS][NUM_VCS],
    input  logic [VC_ID_BITS-1:0]       req_ovc_id          [NUM_PORTS][NUM_VCS],
    input  logic [CREDIT_CTR_WIDTH-1:0] ovc_credits_count_r [NUM_PORTS][NUM_VCS],
    output logic [NUM_VCS-1:0]          sw_allocated_r      [NUM_PORTS],
    output logic [PORT_BITS-1:0]        xbar_sel_r          [NUM_PORTS],
    output logic [NUM_PORTS-1:0]        xbar_valid_r
);

    logic [NUM_VCS-1:0]     elig    [NUM_PORTS];
    logic [NUM_VCS-1:0]     s1_gnt  [NUM_PORTS];
    logic [NUM_PORTS-1:0]   s1_any;
    logic [VC_PTR_BITS-1:0] s1_idx  [NUM_PORTS];
    logic [PORT_BITS-1:0]   s1_dir  [NUM_PORTS];
    logic [VC_ID_BITS-1:0]  s1_ovc  [NUM_PORTS];
    logic [NUM_PORTS-1:0]   s2_req  [NUM_PORTS];
    logic [NUM_PORTS-1:0]   s2_gnt  [NUM_PORTS];
    logic [NUM_PORTS-1:0]   s2_any;
    logic [NUM_PORTS-1:0]   in_won;

    logic [VC_PTR_BITS-1:0] in_ptr_q  [NUM_PORTS];
    logic [VC_PTR_BITS-1:0] in_ptr_d  [NUM_PORTS];
    logic [PORT_BITS-1:0]   out_ptr_q [NUM_PORTS];
    logic [PORT_BITS-1:0]   out_ptr_d [NUM_PORTS];
    logic [NUM_VCS-1:0]     pend_q    [NUM_PORTS];
    logic [NUM_VCS-1:0]     pend_d    [NUM_PORTS];
    logic [NUM_VCS-1:0]     alloc_q   [NUM_PORTS];
    logic [NUM_VCS-1:0]     alloc_d   [NUM_PORTS];
    logic [PORT_BITS-1:0]   sel_q     [NUM_PORTS];
    logic [PORT_BITS-1:0]   sel_d     [NUM_PORTS];
    logic [NUM_PORTS-1:0]   vld_q;
    logic [NUM_PORTS-1:0]   vld_d;

    // Eligibility: valid direction and a credit left once last cycle's grant to that output VC is accounted for.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            for (int v = 0; v < NUM_VCS; v++) begin
                elig[p][v] = 1'b0;
                if (dir_valid(req_dir[p][v])) begin
                    for (int o = 0; o < NUM_PORTS; o++) begin
                        for (int c = 0; c < NUM_VCS; c++) begin
                            if ((dir_port(req_dir[p][v]) == PORT_BITS'(o)) &&
                                (req_ovc_id[p][v] == VC_ID_BITS'(c))) begin
                                elig[p][v] = pend_q[o][c] ? (ovc_credits_count_r[o][c] > CRED_ONE)
                                                          : (ovc_credits_count_r[o][c] != '0);
                            end
                        end
                    end
                end
            end
        end
    end

    for (genvar gp = 0; gp < NUM_PORTS; gp++) begin : g_in_arb
        rr_arbiter #(.N(NUM_VCS)) u_in_arb (
            .req_i (elig[gp]),
            .ptr_i (in_ptr_q[gp]),
            .gnt_o (s1_gnt[gp]),
            .any_o (s1_any[gp])
        );
    end

    // Decode each input's stage-1 winner into VC index, target output port and target output VC.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            s1_idx[p] = '0;
            s1_dir[p] = '0;
            s1_ovc[p] = '0;
            for (int v = 0; v < NUM_VCS; v++) begin
                if (s1_gnt[p][v]) begin
                    s1_idx[p] = VC_PTR_BITS'(v);
                    s1_dir[p] = dir_port(req_dir[p][v]);
                    s1_ovc[p] = req_ovc_id[p][v];
                end
            end
        end
    end

    // Stage-2 request matrix: output o sees every input whose stage-1 winner targets it.
    always_comb begin
        for (int o = 0; o < NUM_PORTS; o++) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                s2_req[o][p] = s1_any[p] && (s1_dir[p] == PORT_BITS'(o));
            end
        end
    end

    for (genvar go = 0; go < NUM_PORTS; go++) begin : g_out_arb
        rr_arbiter #(.N(NUM_PORTS)) u_out_arb (
            .req_i (s2_req[go]),
            .ptr_i (out_ptr_q[go]),
            .gnt_o (s2_gnt[go]),
            .any_o (s2_any[go])
        );
    end

    // Input-side next state: final grant per input and its round-robin pointer.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            in_won[p] = 1'b0;
            for (int o = 0; o < NUM_PORTS; o++) begin
                if (s2_gnt[o][p]) begin
                    in_won[p] = 1'b1;
                end
            end
            alloc_d[p]  = in_won[p] ? s1_gnt[p] : '0;
            in_ptr_d[p] = in_ptr_q[p];
`ifdef SA_ISLIP_EN
            if (in_won[p]) begin
`else
            if (s1_any[p]) begin
`endif
                in_ptr_d[p] = (int'(s1_idx[p]) == NUM_VCS - 1) ? '0 : s1_idx[p] + 1'b1;
            end
        end
    end

    // Output-side next state: crossbar select/valid, output pointer, and the pending-credit history.
    always_comb begin
        for (int o = 0; o < NUM_PORTS; o++) begin
            vld_d[o]     = s2_any[o];
            sel_d[o]     = sel_q[o];
            out_ptr_d[o] = out_ptr_q[o];
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (s2_gnt[o][p]) begin
                    sel_d[o]     = PORT_BITS'(p);
                    out_ptr_d[o] = (p == NUM_PORTS - 1) ? '0 : PORT_BITS'(p + 1);
                end
            end
            for (int c = 0; c < NUM_VCS; c++) begin
                pend_d[o][c] = 1'b0;
                for (int p = 0; p < NUM_PORTS; p++) begin
                    if (in_won[p] && (s1_dir[p] == PORT_BITS'(o)) && (s1_ovc[p] == VC_ID_BITS'(c))) begin
                        pend_d[o][c] = 1'b1;
                    end
                end
            end
        end
    end

    // Grant, crossbar and pointer registers; reset drops every grant immediately.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                in_ptr_q[i]  <= '0;
                out_ptr_q[i] <= '0;
                pend_q[i]    <= '0;
                alloc_q[i]   <= '0;
                sel_q[i]     <= '0;
            end
            vld_q <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                in_ptr_q[i]  <= in_ptr_d[i];
                out_ptr_q[i] <= out_ptr_d[i];
                pend_q[i]    <= pend_d[i];
                alloc_q[i]   <= alloc_d[i];
                sel_q[i]     <= sel_d[i];
            end
            vld_q <= vld_d;
        end
    end

    assign sw_allocated_r = alloc_q;
    assign xbar_sel_r     = sel_q;
    assign xbar_valid_r   = vld_q;

endmodule

// File: tb/tb_switch_allocator.sv
// Directed, table-driven bench for switch_allocator with hand-computed grants.
// Latency: each vector is driven at negedge and checked 1ns after the following posedge.
// Backpressure: credit corner cases are encoded directly in the vectors.
module tb_switch_allocator;
    import router_pkg::*;

    logic clk = 1'b0;
    logic arst_n;
    always #5 clk = ~clk;

    dir_t                        req_dir             [NUM_PORTS][NUM_VCS];
    logic [VC_ID_BITS-1:0]       req_ovc_id          [NUM_PORTS][NUM_VCS];
    logic [CREDIT_CTR_WIDTH-1:0] ovc_credits_count_r [NUM_PORTS][NUM_VCS];
    logic [NUM_VCS-1:0]          sw_allocated_r      [NUM_PORTS];
    logic [PORT_BITS-1:0]        xbar_sel_r          [NUM_PORTS];
    logic [NUM_PORTS-1:0]        xbar_valid_r;

    switch_allocator dut (
        .clk                 (clk),
        .arst_n              (arst_n),
        .req_dir             (req_dir),
        .req_ovc_id          (req_ovc_id),
        .ovc_credits_count_r (ovc_credits_count_r),
        .sw_allocated_r      (sw_allocated_r),
        .xbar_sel_r          (xbar_sel_r),
        .xbar_valid_r        (xbar_valid_r)
    );

    // Flattened index: request fields use p*2+v, credits use o*2+vc, alloc bit p*2+v.
    typedef struct {
        logic [2:0] dir  [10];
        logic       ovc  [10];
        logic [3:0] cred [10];
        logic [9:0] alloc;
        logic [4:0] vld;
        logic [2:0] sel  [5];
        logic [4:0] sel_mask;
    } vec_t;

    vec_t tbl[$];
    int checks = 0;
    int errors = 0;

    function automatic vec_t blank();
        vec_t v;
        for (int i = 0; i < 10; i++) begin
            v.dir[i]  = 3'd7;
            v.ovc[i]  = 1'b0;
            v.cred[i] = 4'd4;
        end
        for (int o = 0; o < 5; o++) v.sel[o] = 3'd0;
        v.alloc    = '0;
        v.vld      = '0;
        v.sel_mask = '0;
        return v;
    endfunction

    task automatic push(input vec_t v);
        v.sel_mask = v.sel_mask | v.vld;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [9:0] got_alloc();
        logic [9:0] r;
        for (int p = 0; p < 5; p++)
            for (int v = 0; v < 2; v++)
                r[p*2+v] = sw_allocated_r[p][v];
        return r;
    endfunction

    function automatic logic [14:0] got_sel();
        logic [14:0] r;
        for (int o = 0; o < 5; o++) r[o*3 +: 3] = xbar_sel_r[o];
        return r;
    endfunction

    task automatic apply(input vec_t v);
        for (int p = 0; p < 5; p++)
            for (int q = 0; q < 2; q++) begin
                req_dir[p][q]             = dir_t'(v.dir[p*2+q]);
                req_ovc_id[p][q]          = v.ovc[p*2+q];
                ovc_credits_count_r[p][q] = v.cred[p*2+q];
            end
    endtask

    task automatic check_vec(input string tag, input vec_t v);
        logic one_hot_ok;
        chk({tag, " alloc"}, 32'(got_alloc()), 32'(v.alloc));
        chk({tag, " xbar_valid"}, 32'(xbar_valid_r), 32'(v.vld));
        for (int o = 0; o < 5; o++)
            if (v.sel_mask[o])
                chk($sformatf("%s xbar_sel[%0d]", tag, o), 32'(xbar_sel_r[o]), 32'(v.sel[o]));
        one_hot_ok = 1'b1;
        for (int p = 0; p < 5; p++)
            if ($countones(sw_allocated_r[p]) > 1) one_hot_ok = 1'b0;
        chk({tag, " per-input one-hot"}, 32'(one_hot_ok), 32'd1);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, " alloc"}, 32'(got_alloc()), 32'd0);
        chk({tag, " xbar_valid"}, 32'(xbar_valid_r), 32'd0);
        chk({tag, " xbar_sel"}, 32'(got_sel()), 32'd0);
    endtask

    initial begin
        vec_t v;

        // V0..V3: inputs 0 (VC0) and 2 (VC1) contend for EAST; output pointer alternates them.
        for (int k = 0; k < 4; k++) begin
            v = blank(); v.dir[0] = 3'd1; v.dir[5] = 3'd1; v.ovc[5] = 1'b1;
            v.alloc = (k % 2 == 0) ? 10'b0000000001 : 10'b0000100000;
            v.vld = 5'b00010; v.sel[1] = (k % 2 == 0) ? 3'd0 : 3'd2;
            push(v);
        end
        // V4..V7: input 1 VC0 to SOUTH; 1 credit grants once, then blocks, 2 credits grant back-to-back.
        for (int k = 0; k < 4; k++) begin
            v = blank(); v.dir[2] = 3'd2; v.cred[4] = (k < 2) ? 4'd1 : 4'd2;
            if (k != 1) begin v.alloc = 10'b0000000100; v.vld = 5'b00100; v.sel[2] = 3'd1; end
            push(v);
        end
        // V8..V11: input 3 VC0->NORTH, VC1->WEST; input 4 VC0 also wants NORTH.
        for (int k = 0; k < 4; k++) begin
            v = blank(); v.dir[6] = 3'd4; v.dir[7] = 3'd3; v.dir[8] = 3'd4; v.ovc[8] = 1'b1;
            if (k % 2 == 0) begin v.alloc = 10'b0001000000; v.vld = 5'b10000; v.sel[4] = 3'd3; end
            else begin v.alloc = 10'b0110000000; v.vld = 5'b11000; v.sel[3] = 3'd3; v.sel[4] = 3'd4; end
            push(v);
        end
        // V12: input 3 VC1 takes NORTH alone, moving NORTH's pointer past input 3.
        v = blank(); v.dir[7] = 3'd4; v.ovc[7] = 1'b1;
        v.alloc = 10'b0010000000; v.vld = 5'b10000; v.sel[4] = 3'd3; push(v);
        // V13: input 3 picks VC0->NORTH but loses to input 4.
        v = blank(); v.dir[6] = 3'd4; v.dir[7] = 3'd3; v.dir[8] = 3'd4; v.ovc[8] = 1'b1;
        v.alloc = 10'b0100000000; v.vld = 5'b10000; v.sel[4] = 3'd4; push(v);
        // V14: same requests; the input pointer rule decides what input 3 tries next.
`ifdef SA_ISLIP_EN
        v.alloc = 10'b0001000000; v.vld = 5'b10000; v.sel[4] = 3'd3; push(v);
`else
        v.alloc = 10'b0110000000; v.vld = 5'b11000; v.sel[3] = 3'd3; v.sel[4] = 3'd4; push(v);
`endif
        // V15: five inputs to five distinct outputs, all granted together.
        v = blank(); v.dir[0] = 3'd4; v.dir[2] = 3'd0; v.dir[4] = 3'd3; v.dir[7] = 3'd1; v.dir[8] = 3'd2;
        v.alloc = 10'b0110010101; v.vld = 5'b11111;
        v.sel[0] = 3'd1; v.sel[1] = 3'd3; v.sel[2] = 3'd4; v.sel[3] = 3'd2; v.sel[4] = 3'd0;
        push(v);
        // V16: no requests; crossbar selects must hold.
        v = blank(); v.sel_mask = 5'b11111;
        v.sel[0] = 3'd1; v.sel[1] = 3'd3; v.sel[2] = 3'd4; v.sel[3] = 3'd2; v.sel[4] = 3'd0;
        push(v);
        // V17: out-of-range direction and a zero-credit target are both ineligible.
        v.dir[0] = 3'd5; v.dir[2] = 3'd1; v.ovc[2] = 1'b1; v.cred[3] = 4'd0;
        push(v);
        // V18: zero-credit VC skipped, the other VC of the same input is granted.
        v = blank(); v.dir[2] = 3'd1; v.ovc[2] = 1'b1; v.cred[3] = 4'd0; v.dir[3] = 3'd2;
        v.alloc = 10'b0000001000; v.vld = 5'b00100; v.sel[2] = 3'd1; push(v);

        // Reset held with random requests: no grant may appear.
        arst_n = 1'b0;
        apply(blank());
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            for (int p = 0; p < 5; p++)
                for (int q = 0; q < 2; q++) begin
                    req_dir[p][q]             = dir_t'(3'($urandom_range(0, 4)));
                    req_ovc_id[p][q]          = 1'($urandom_range(0, 1));
                    ovc_credits_count_r[p][q] = 4'($urandom_range(0, 15));
                end
            @(posedge clk); #1;
            check_idle($sformatf("reset_held%0d", c));
        end
        @(negedge clk);
        apply(blank());
        arst_n = 1'b1;
        @(posedge clk); #1;
        check_idle("post_release_idle");

        foreach (tbl[i]) begin
            @(negedge clk);
            apply(tbl[i]);
            if (i == 0) begin
                #1;
                chk("first_req_not_yet_granted", 32'(got_alloc()), 32'd0);
            end
            @(posedge clk); #1;
            check_vec($sformatf("vec%0d", i), tbl[i]);
        end

        // Mid-operation reset: steer pointers to non-zero, reset, confirm they restart at 0.
        @(negedge clk);
        v = blank(); v.dir[1] = 3'd0;
        apply(v);
        @(posedge clk); #1;
        v.alloc = 10'b0000000010; v.vld = 5'b00001; v.sel[0] = 3'd0; v.sel_mask = 5'b00001;
        check_vec("rst_prep", v);
        @(negedge clk);
        v = blank(); v.dir[0] = 3'd1; v.dir[1] = 3'd1; v.ovc[1] = 1'b1; v.dir[2] = 3'd1;
        apply(v);
        @(posedge clk); #1;
        v.alloc = 10'b0000000001; v.vld = 5'b00010; v.sel[1] = 3'd0; v.sel_mask = 5'b00010;
        check_vec("rst_grant_cycle", v);
        #3;
        arst_n = 1'b0;
        #1;
        check_idle("rst_async_drop");
        @(posedge clk); #1;
        check_idle("rst_held");
        @(negedge clk);
        arst_n = 1'b1;
        @(posedge clk); #1;
        check_vec("rst_ptrs_restart", v);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1);
    end

endmodule
